// File: rtl/core_v2_pkg.sv
// Shared opcode encodings, FSM state type and decode helpers for the v2 core.
package core_v2_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LI   = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_BZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } core_state_t;

  // ALU ops and LI are the only instructions that update the register file.
  function automatic logic op_writes(input logic [2:0] op);
    return (op[2] == 1'b0) || (op == OP_LI);
  endfunction

endpackage

// File: rtl/core_v2_regfile.sv
// Register file: NREGS x DATA_W, one synchronous write port, two async read
// ports with write-through so ID sees the value being written this cycle.
module core_v2_regfile #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREGS = 2 ** RA_W;

  logic [DATA_W-1:0] regs [NREGS];

  // Clear every register on reset, otherwise store the write-back result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/pipelined_core_v2.sv
// Four-stage (IF, ID, EX, WB) core with EX-resolved branches, EX/WB
// forwarding, a global enable and a RUN/HALTED state machine.
module pipelined_core_v2 #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3,
  parameter int PC_W   = 8,
  localparam int INSTR_W = 3 + 2 * RA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               wb_valid,
  output logic [RA_W-1:0]    wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               halted
);

  import core_v2_pkg::*;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } if_id_t;

  typedef struct packed {
    logic              valid;
    logic [2:0]        op;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [PC_W-1:0]   pc;
  } id_ex_t;

  typedef struct packed {
    logic              valid;
    logic              writes;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } ex_wb_t;

  logic [PC_W-1:0] pc;
  if_id_t          if_id;
  id_ex_t          id_ex;
  ex_wb_t          ex_wb;
  core_state_t     state, state_next;

  logic [2:0]        id_op;
  logic [RA_W-1:0]   id_rd, id_rs;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic              rf_we;

  logic [DATA_W-1:0] ex_a, ex_b, ex_result;
  logic              ex_writes, ex_taken, ex_halt;
  logic [PC_W-1:0]   ex_target;

  assign id_op = if_id.instr[INSTR_W-1 -: 3];
  assign id_rd = if_id.instr[2*RA_W-1 -: RA_W];
  assign id_rs = if_id.instr[RA_W-1:0];

  assign rf_we = ex_wb.valid & ex_wb.writes & en;

  core_v2_regfile #(
    .DATA_W(DATA_W),
    .RA_W  (RA_W)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (ex_wb.rd),
    .wdata  (ex_wb.data),
    .raddr_a(id_rd),
    .raddr_b(id_rs),
    .rdata_a(rf_a),
    .rdata_b(rf_b)
  );

  // EX stage: forward the EX/WB result into the operands, then compute the
  // ALU result, branch decision/target and halt request for a valid entry.
  always_comb begin
    ex_a      = id_ex.a;
    ex_b      = id_ex.b;
    ex_result = '0;
    ex_taken  = 1'b0;
    ex_halt   = 1'b0;
    ex_target = PC_W'({id_ex.rd, id_ex.rs});
    if (ex_wb.valid && ex_wb.writes && (ex_wb.rd == id_ex.rd)) begin
      ex_a = ex_wb.data;
    end
    if (ex_wb.valid && ex_wb.writes && (ex_wb.rd == id_ex.rs)) begin
      ex_b = ex_wb.data;
    end
    case (id_ex.op)
      OP_ADD:  ex_result = ex_a + ex_b;
      OP_SUB:  ex_result = ex_a - ex_b;
      OP_AND:  ex_result = ex_a & ex_b;
      OP_OR:   ex_result = ex_a | ex_b;
      OP_LI:   ex_result = DATA_W'($signed(id_ex.rs));
      OP_JMP:  ex_taken  = id_ex.valid;
      OP_BZ: begin
        ex_taken  = id_ex.valid && (ex_a == '0);
        ex_target = id_ex.pc + PC_W'($signed(id_ex.rs));
      end
      default: ex_halt = id_ex.valid;
    endcase
    ex_writes = id_ex.valid && op_writes(id_ex.op);
  end

  // State register for the RUN/HALTED machine; only reset leaves HALTED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a valid HALT in EX stops the core at an enabled edge.
  always_comb begin
    state_next = state;
    if (en && (state == ST_RUN) && ex_halt) begin
      state_next = ST_HALTED;
    end
  end

  // PC and pipeline registers: advance when enabled; a taken branch or a
  // halt (or being halted) squashes the two younger entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      if_id <= '0;
      id_ex <= '0;
      ex_wb <= '0;
    end else if (en) begin
      ex_wb.valid  <= id_ex.valid;
      ex_wb.writes <= ex_writes;
      ex_wb.rd     <= id_ex.rd;
      ex_wb.data   <= ex_result;
      if ((state == ST_HALTED) || ex_halt) begin
        if_id.valid <= 1'b0;
        id_ex.valid <= 1'b0;
      end else if (ex_taken) begin
        pc          <= ex_target;
        if_id.valid <= 1'b0;
        id_ex.valid <= 1'b0;
      end else begin
        pc          <= pc + PC_W'(1);
        if_id.valid <= 1'b1;
        if_id.instr <= imem_data;
        if_id.pc    <= pc;
        id_ex.valid <= if_id.valid;
        id_ex.op    <= id_op;
        id_ex.rd    <= id_rd;
        id_ex.rs    <= id_rs;
        id_ex.a     <= rf_a;
        id_ex.b     <= rf_b;
        id_ex.pc    <= if_id.pc;
      end
    end
  end

  assign imem_addr = pc;
  assign wb_valid  = rf_we;
  assign wb_addr   = ex_wb.rd;
  assign wb_data   = ex_wb.data;
  assign halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_pipelined_core_v2.sv
// Scoreboard bench: an instruction-level model of each program predicts the
// write-back stream, the fetch address per enabled cycle and the halt cycle.
module tb_pipelined_core_v2;
  import core_v2_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       halted;

  logic [8:0] imem [256];

  typedef struct {
    int cyc;
    int rd;
    int data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int      expPc [1024];
  int      haltSlot;
  int      haltPc;
  int      count;
  int      checks = 0;
  int      errors = 0;

  pipelined_core_v2 dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .halted   (halted)
  );

  assign imem_data = imem[imem_addr];

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, count);
    end
  endtask

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {op, rd, rs};
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 256; i++) imem[i] = enc(OP_HALT, 3'd0, 3'd0);
  endtask

  // Sequential execution of the program in imem from address 0.
  task automatic modelRun();
    logic [7:0] regs [8];
    logic [7:0] pc, nxt1, nxt2, a, b, res;
    logic [8:0] ins;
    logic [2:0] op, rd, rs;
    int         slot;
    wb_exp_t    e;
    sb.delete();
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    pc = 8'h00;
    slot = 0;
    haltSlot = 1000;
    haltPc = 0;
    for (int step = 0; step < 300; step++) begin
      ins = imem[pc];
      op = ins[8:6];
      rd = ins[5:3];
      rs = ins[2:0];
      a = regs[rd];
      b = regs[rs];
      nxt1 = pc + 8'd1;
      nxt2 = pc + 8'd2;
      expPc[slot] = int'(pc);
      if (op == OP_HALT) begin
        haltSlot = slot;
        expPc[slot+1] = int'(nxt1);
        haltPc = int'(nxt2);
        break;
      end else if (op == OP_JMP || (op == OP_BZ && a == 8'h00)) begin
        expPc[slot+1] = int'(nxt1);
        expPc[slot+2] = int'(nxt2);
        if (op == OP_JMP) pc = {2'b00, rd, rs};
        else pc = pc + {{5{rs[2]}}, rs};
        slot += 3;
      end else if (op == OP_BZ) begin
        pc = nxt1;
        slot += 1;
      end else begin
        case (op)
          OP_ADD:  res = a + b;
          OP_SUB:  res = a - b;
          OP_AND:  res = a & b;
          OP_OR:   res = a | b;
          default: res = {{5{rs[2]}}, rs};
        endcase
        regs[rd] = res;
        e.cyc = slot + 3;
        e.rd = int'(rd);
        e.data = int'(res);
        sb.push_back(e);
        pc = nxt1;
        slot += 1;
      end
    end
  endtask

  function automatic int expectedPc(input int n);
    return (n >= haltSlot + 2) ? haltPc : expPc[n];
  endfunction

  // Reset the core, then run the current program, comparing every cycle.
  task automatic applyStimulus(input int enPct, input int stallAt, input int stopAt);
    int      it;
    logic    expWb;
    wb_exp_t e;
    modelRun();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    count = 0;
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_addr", wb_addr, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_imem_addr", imem_addr, 0);
    it = 0;
    while (count < haltSlot + 6 && count < stopAt && it < 2000) begin
      if (it >= stallAt && it < stallAt + 3) en = 1'b0;
      else en = ($urandom_range(99) < enPct);
      @(posedge clk);
      @(negedge clk);
      if (en) count++;
      it++;
      checkOutput("imem_addr", imem_addr, expectedPc(count));
      checkOutput("halted", halted, count >= haltSlot + 3);
      if (en) begin
        expWb = (sb.size() > 0) && (sb[0].cyc == count);
        checkOutput("wb_valid", wb_valid, expWb);
        if (wb_valid && expWb) begin
          e = sb.pop_front();
          checkOutput("wb_addr", wb_addr, e.rd);
          checkOutput("wb_data", wb_data, e.data);
        end
      end else begin
        checkOutput("wb_valid_stall", wb_valid, 0);
      end
    end
    en = 1'b1;
    checkOutput("run_in_budget", it < 2000, 1);
    if (count >= haltSlot + 6) checkOutput("sb_empty", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    count = 0;
    clearMem();

    // Forwarding: back-to-back dependent ADD
    imem[0] = enc(OP_LI, 3'd1, 3'd3);
    imem[1] = enc(OP_LI, 3'd2, 3'b110);
    imem[2] = enc(OP_ADD, 3'd1, 3'd2);
    applyStimulus(100, 9999, 9999);

    // Write-through into ID
    clearMem();
    imem[0] = enc(OP_LI, 3'd3, 3'd5);
    imem[1] = enc(OP_ADD, 3'd4, 3'd4);
    imem[2] = enc(OP_ADD, 3'd3, 3'd3);
    applyStimulus(100, 9999, 9999);

    // Jump flush
    clearMem();
    imem[0] = enc(OP_LI, 3'd1, 3'd1);
    imem[1] = enc(OP_LI, 3'd2, 3'd2);
    imem[2] = enc(OP_LI, 3'd3, 3'd3);
    imem[3] = enc(OP_LI, 3'd4, 3'd1);
    imem[4] = enc(OP_JMP, 3'd4, 3'd0);
    imem[5] = enc(OP_LI, 3'd5, 3'd1);
    imem[6] = enc(OP_LI, 3'd6, 3'd1);
    imem[7] = enc(OP_LI, 3'd7, 3'd1);
    imem[32] = enc(OP_LI, 3'd7, 3'd2);
    imem[33] = enc(OP_ADD, 3'd7, 3'd1);
    applyStimulus(100, 9999, 9999);

    // Branch taken (r5 = 0) then not taken (r5 = 1)
    for (int pass = 0; pass < 2; pass++) begin
      clearMem();
      imem[0] = enc(OP_LI, 3'd5, pass[2:0]);
      imem[1] = enc(OP_LI, 3'd1, 3'd1);
      for (int i = 2; i < 8; i++) imem[i] = enc(OP_ADD, 3'd2, 3'd1);
      imem[8] = enc(OP_BZ, 3'd5, 3'd2);
      imem[9] = enc(OP_LI, 3'd6, 3'd1);
      imem[10] = enc(OP_LI, 3'd7, 3'd3);
      applyStimulus(100, 9999, 9999);
    end

    // Halt: younger LI must never write, PC freezes
    clearMem();
    imem[0] = enc(OP_LI, 3'd1, 3'd7);
    imem[1] = enc(OP_HALT, 3'd0, 3'd0);
    imem[2] = enc(OP_LI, 3'd2, 3'd1);
    applyStimulus(100, 9999, 9999);

    // Three-cycle stall mid-stream
    clearMem();
    imem[0] = enc(OP_LI, 3'd1, 3'd3);
    imem[1] = enc(OP_LI, 3'd2, 3'b110);
    imem[2] = enc(OP_ADD, 3'd1, 3'd2);
    imem[3] = enc(OP_SUB, 3'd2, 3'd1);
    imem[4] = enc(OP_OR, 3'd3, 3'd2);
    imem[5] = enc(OP_AND, 3'd3, 3'd1);
    applyStimulus(100, 4, 9999);

    // Reset mid-stream: registers must read 0 after the restart
    clearMem();
    imem[0] = enc(OP_ADD, 3'd1, 3'd1);
    imem[1] = enc(OP_ADD, 3'd2, 3'd2);
    imem[2] = enc(OP_LI, 3'd1, 3'd3);
    imem[3] = enc(OP_LI, 3'd2, 3'b110);
    imem[4] = enc(OP_ADD, 3'd1, 3'd2);
    imem[5] = enc(OP_SUB, 3'd2, 3'd1);
    applyStimulus(100, 9999, 8);
    applyStimulus(100, 9999, 9999);

    // Random programs with forward branches and random enable
    for (int r = 0; r < 3; r++) begin
      clearMem();
      for (int i = 0; i < 40; i++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 5));
        if (op == 3'd5) imem[i] = enc(OP_BZ, 3'($urandom_range(0, 7)), 3'($urandom_range(1, 3)));
        else imem[i] = enc(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      applyStimulus(75, 9999, 9999);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_core_v2.md
Name: pipelined_core_v2

Overview:
- Parametrised successor to the 3-register-stage processor: IF, ID, EX, WB with pipeline registers IF/ID, ID/EX, EX/WB.
- Generalised data width, register count and PC width.
- Adds branch/jump with flush, a global stall input, a HALT state machine, and a write-back observation port.
- Fetches from an external combinational instruction memory and is the top of the core.

Parameters:
- DATA_W, 8, datapath and register width.
- RA_W, 3, register address width; NREGS = 2**RA_W.
- PC_W, 8, program counter width; INSTR_W = 3 + 2*RA_W is derived, not overridable.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  1 = pipeline advances; 0 = all state (PC, pipe regs, regfile, FSM) holds.
- imem_addr  out  PC_W  fetch address, equals PC.
- imem_data  in  INSTR_W  instruction at imem_addr, same cycle.
- wb_valid  out  1  a register write occurs this cycle.
- wb_addr  out  RA_W  destination register of that write.
- wb_data  out  DATA_W  data being written.
- halted  out  1  core has executed HALT.

Behaviour:
- Instruction format: op = [INSTR_W-1 -: 3], rd = next RA_W bits, rs = low RA_W bits.
- Opcodes:
  - 000 ADD: R[rd] = R[rd] + R[rs].
  - 001 SUB: R[rd] = R[rd] - R[rs].
  - 010 AND.
  - 011 OR.
  - 100 LI: R[rd] = sign-extend(rs field).
  - 101 JMP: PC = zero-extend/truncate({rd,rs}) to PC_W.
  - 110 BZ: if R[rd]==0, PC = PC_of_BZ + sign-extend(rs).
  - 111 HALT.
- Arithmetic wraps mod 2^DATA_W; PC arithmetic wraps mod 2^PC_W.
- Reset (at the clk edge with reset=1):
  - PC=0; IF/ID, ID/EX, EX/WB valid bits=0 (bubbles).
  - All NREGS registers = 0; FSM=RUN.
  - Outputs: wb_valid=0, wb_addr=0, wb_data=0, halted=0, imem_addr=0.
  - Reset overrides en and any in-flight operation.
- Each pipe register carries a valid bit; an invalid entry never writes, branches or halts.
- Normal flow (en=1, RUN): PC += 1 each cycle; latency from fetch to WB is 3 cycles, throughput 1 per cycle.
- Register file: 2 async read ports in ID, 1 write port in WB. Write-through: an ID read of the register being written that cycle returns the new data.
- Forwarding: if EX/WB is valid and writes, and EX/WB.rd equals an EX source (rd or rs operand), the EX operand takes the EX/WB result. Sources are rd and rs for ALU ops, rd for BZ.
- No other hazards exist; there are no stalls except en.
- Control flow resolves in EX. A taken JMP/BZ:
  - loads PC with the target;
  - invalidates IF/ID and ID/EX, giving a 2-cycle penalty;
  - the instruction itself continues to WB as a non-writing entry.
- A not-taken BZ has no effect.
- FSM states and transitions:
  - RUN: a valid HALT in EX moves to HALTED at the edge.
  - At that edge: PC frozen, IF/ID and ID/EX invalidated; the older instruction in EX/WB still completes; HALT enters EX/WB as a non-writing entry.
  - HALTED: halted=1; PC holds; fetched instructions are not latched (IF/ID stays invalid).
  - Exit from HALTED only by reset.
- HALT or branch sitting in a flushed slot has no effect.
- en=0 in any state: nothing changes. Outputs derived from EX/WB (wb_*) stay constant, so a bench samples wb_* only when en=1.
- wb_valid = EX/WB.valid & writes & en.

Decomposition:
- Package core_v2_pkg holds:
  - opcode localparams OP_ADD..OP_HALT;
  - FSM state encoding (RUN, HALTED);
  - packed typedefs for the IF/ID, ID/EX and EX/WB entries, parametrised via the core's widths or defined in the core.
- One sub-module, core_v2_regfile: NREGS x DATA_W, synchronous write, async read, write-through bypass, synchronous reset clear.
- ALU, forwarding and branch logic stay inline.

Test Plan (default params, INSTR_W=9):
1. Forwarding: reset, then LI r1,3; LI r2,-2 (rs=3'b110); ADD r1,r2 back-to-back -> wb sequence (1,3), (2,0xFE), (1,0x01).
2. Write-through: LI r3,5; ADD r4,r4 (filler); ADD r3,r3 -> r3 written 0x0A; the filler writes r4=0.
3. Jump flush: JMP 0x20 at addr 4 -> addrs 5,6 never produce wb_valid; imem_addr=0x20 on the cycle after JMP leaves EX; the instruction at 0x20 writes back 3 cycles later.
4. Branch: at addr 8, with r5=0: BZ r5,+2 -> next fetch 0x0A. Repeat with r5=1 -> falls through to 9, no flush, no lost writes.
5. Halt: LI r1,7; HALT; LI r2,1 -> r1=7 written, r2 never written, halted=1 from the edge HALT leaves EX; imem_addr frozen; reset returns halted=0, PC=0.
6. Stall/reset: en=0 for 3 cycles mid-stream -> same wb_* sequence as with no stall, no duplicates or drops; reset asserted mid-stream -> all registers read 0 and the wb stream restarts from addr 0.
